// File: rtl/clock_domain_export_arbiter.sv
// Round-robin arbiter that shares one clock_domain_exporter channel between Ports requesters.
// Define CLOCK_DOMAIN_EXPORT_ARBITER_TAG_EN to prefix data_o with the granted index.
module clock_domain_export_arbiter #(
    parameter int Bits    = 8,
    parameter int Ports   = 4,
    parameter int IdxBits = $clog2(Ports)
) (
    input  logic                    clk_i,
    input  logic                    rst_i,
    input  logic [Ports-1:0]        req_i,
    input  logic [Ports*Bits-1:0]   data_i,
    output logic [Ports-1:0]        ack_o,
    output logic                    stb_o,
`ifdef CLOCK_DOMAIN_EXPORT_ARBITER_TAG_EN
    output logic [IdxBits+Bits-1:0] data_o,
`else
    output logic [Bits-1:0]         data_o,
`endif
    input  logic                    ready_i,
    output logic [IdxBits-1:0]      grant_o,
    output logic                    busy_o
);

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        STROBE = 2'd1,
        SETTLE = 2'd2
    } state_t;

    state_t           state;
    logic [Bits-1:0]  data_q;
    logic [IdxBits-1:0] pick;
    logic             found;

    // (base + off) mod Ports; Ports need not be a power of two
    function automatic logic [IdxBits-1:0] wrap_add(input logic [IdxBits-1:0] base, input int off);
        int sum;
        sum = int'(base) + off;
        if (sum >= Ports) sum = sum - Ports;
        return IdxBits'(sum);
    endfunction

    // First requester after the last grant, wrapping; the last grantee is checked last.
    always_comb begin
        pick  = grant_o;
        found = 1'b0;
        for (int i = 1; i <= Ports; i++) begin
            if (!found && req_i[wrap_add(grant_o, i)]) begin
                pick  = wrap_add(grant_o, i);
                found = 1'b1;
            end
        end
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            state   <= IDLE;
            stb_o   <= 1'b0;
            ack_o   <= '0;
            busy_o  <= 1'b0;
            data_q  <= '0;
            grant_o <= IdxBits'(Ports - 1);
        end else begin
            stb_o <= 1'b0;
            ack_o <= '0;
            case (state)
                IDLE: begin
                    if (ready_i && found) begin
                        data_q      <= data_i[int'(pick)*Bits +: Bits];
                        grant_o     <= pick;
                        ack_o[pick] <= 1'b1;
                        stb_o       <= 1'b1;
                        busy_o      <= 1'b1;
                        state       <= STROBE;
                    end
                end
                STROBE: state <= SETTLE;
                // Exporter ready is still stale here; it drops one cycle after the strobe.
                SETTLE: begin
                    busy_o <= 1'b0;
                    state  <= IDLE;
                end
                default: begin
                    busy_o <= 1'b0;
                    state  <= IDLE;
                end
            endcase
        end
    end

`ifdef CLOCK_DOMAIN_EXPORT_ARBITER_TAG_EN
    assign data_o = {grant_o, data_q};
`else
    assign data_o = data_q;
`endif

endmodule

// File: tb/tb_clock_domain_export_arbiter.sv
// Directed bench for clock_domain_export_arbiter (Bits=8, Ports=4); tag-aware when
// CLOCK_DOMAIN_EXPORT_ARBITER_TAG_EN is defined.
module tb_clock_domain_export_arbiter;

    localparam int Bits    = 8;
    localparam int Ports   = 4;
    localparam int IdxBits = 2;
`ifdef CLOCK_DOMAIN_EXPORT_ARBITER_TAG_EN
    localparam int OutBits = IdxBits + Bits;
`else
    localparam int OutBits = Bits;
`endif

    logic                    clk = 1'b0;
    logic                    rst;
    logic [Ports-1:0]        req;
    logic [Ports*Bits-1:0]   data;
    logic [Ports-1:0]        ack;
    logic                    stb;
    logic [OutBits-1:0]      dout;
    logic                    ready;
    logic [IdxBits-1:0]      grant;
    logic                    busy;

    int vectors = 0;
    int miscompares = 0;

    clock_domain_export_arbiter #(.Bits(Bits), .Ports(Ports)) dut (
        .clk_i(clk), .rst_i(rst), .req_i(req), .data_i(data), .ack_o(ack),
        .stb_o(stb), .data_o(dout), .ready_i(ready), .grant_o(grant), .busy_o(busy)
    );

    always #5 clk = ~clk;

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        vectors++;
        assert (obs === exp) else begin
            miscompares++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    // Expected data_o for a word granted to requester k
    function automatic logic [31:0] exp_out(input int k, input logic [7:0] w);
`ifdef CLOCK_DOMAIN_EXPORT_ARBITER_TAG_EN
        return {22'd0, 2'(k), w};
`else
        return {24'd0, w};
`endif
    endfunction

    logic [7:0] words [4] = '{8'h11, 8'h22, 8'h33, 8'h44};

    initial begin
        // Reset with all requests and ready high
        rst = 1'b1; req = 4'b1111; ready = 1'b1;
        data = {words[3], words[2], words[1], words[0]};
        step(); step();
        chk("rst_stb", 32'(stb), 0);
        chk("rst_ack", 32'(ack), 0);
        chk("rst_grant", 32'(grant), 3);
        chk("rst_busy", 32'(busy), 0);

        // First grant after release goes to requester 0
        rst = 1'b0;
        step();
        chk("first_ack", 32'(ack), 32'b0001);
        chk("first_stb", 32'(stb), 1);
        chk("first_data", 32'(dout), exp_out(0, 8'h11));
        chk("first_busy", 32'(busy), 1);
        req = 4'b0000;
        step();
        chk("settle_stb", 32'(stb), 0);
        chk("settle_busy", 32'(busy), 1);
        step();
        chk("idle_busy", 32'(busy), 0);

        // Single transfer from requester 2
        req = 4'b0100; data[2*Bits +: Bits] = 8'hA5;
        step();
        chk("single_stb", 32'(stb), 1);
        chk("single_ack", 32'(ack), 32'b0100);
        chk("single_data", 32'(dout), exp_out(2, 8'hA5));
        chk("single_grant", 32'(grant), 2);
        req = 4'b0000;
        step();
        chk("single_gap1_stb", 32'(stb), 0);
        chk("single_gap1_ack", 32'(ack), 0);
        step();
        chk("single_gap2_stb", 32'(stb), 0);
        chk("single_hold_data", 32'(dout), exp_out(2, 8'hA5));
        step();
        chk("single_noreq_ack", 32'(ack), 0);

        // Round-robin with all requesters held high
        rst = 1'b1; step(); rst = 1'b0;
        req = 4'b1111;
        data = {words[3], words[2], words[1], words[0]};
        for (int i = 0; i < 5; i++) begin
            step();
            chk("rr_ack", 32'(ack), 32'(1 << (i % 4)));
            chk("rr_stb", 32'(stb), 1);
            chk("rr_grant", 32'(grant), 32'(i % 4));
            chk("rr_data", 32'(dout), exp_out(i % 4, words[i % 4]));
            step();
            chk("rr_gap_ack", 32'(ack), 0);
            step();
        end

        // Ready backpressure: requester 1 waits while ready is low
        req = 4'b0010; ready = 1'b0;
        for (int i = 0; i < 10; i++) begin
            step();
            chk("bp_stb", 32'(stb), 0);
            chk("bp_ack", 32'(ack), 0);
            chk("bp_busy", 32'(busy), 0);
        end
        chk("bp_grant", 32'(grant), 0);
        ready = 1'b1;
        step();
        chk("bp_rel_stb", 32'(stb), 1);
        chk("bp_rel_ack", 32'(ack), 32'b0010);
        chk("bp_rel_grant", 32'(grant), 1);
        req = 4'b0000;
        step(); step();

        // Reset asserted in the IDLE cycle that would grant requester 1
        req = 4'b0010; rst = 1'b1;
        step();
        chk("rmid_stb", 32'(stb), 0);
        chk("rmid_ack", 32'(ack), 0);
        chk("rmid_grant", 32'(grant), 3);
        chk("rmid_busy", 32'(busy), 0);

        // Requester 3 with pointer at 3: search wraps fully back to it
        rst = 1'b0; req = 4'b1000; data[3*Bits +: Bits] = 8'h3C;
        step();
        chk("tag_ack", 32'(ack), 32'b1000);
        chk("tag_data", 32'(dout), exp_out(3, 8'h3C));
        req = 4'b0000;
        step(); step();

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
